// File: rtl/i_cache_dm_if.sv
// ---------------------------------------------------------------------------
// i_cache_dm_if
// Bus bundle between the fetch stage, the instruction cache and the backing
// instruction memory.
//   CPU side : req_valid/req_ready/req_addr (word address), resp_valid/resp_ins
//   Control  : flush (invalidate all lines)
//   Memory   : mem_req_valid/mem_req_ready/mem_req_addr (line base address),
//              mem_rdata_valid/mem_rdata (refill beats, ascending offsets)
//   Status   : hit_cnt/miss_cnt (saturating)
// Modports: slave = cache view, master = requester/memory view.
// ---------------------------------------------------------------------------
interface i_cache_dm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_ins;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_rdata_valid, mem_rdata,
    output req_ready, resp_valid, resp_ins, mem_req_valid, mem_req_addr,
           hit_cnt, miss_cnt
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_rdata_valid, mem_rdata,
    input  req_ready, resp_valid, resp_ins, mem_req_valid, mem_req_addr,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/i_cache_dm.sv
// ---------------------------------------------------------------------------
// i_cache_dm
// Direct-mapped instruction cache in front of the fetch stage.
//   clk : clock, all logic on the rising edge
//   rst : synchronous reset, active-low
//   bus : i_cache_dm_if.slave (CPU request/response, flush, line refill
//         port towards instruction memory, hit/miss counters)
// A request is latched in IDLE (or during a hit), looked up in COMPARE the
// following cycle, and answered there on a hit. A miss requests the whole
// line, refills it beat by beat, then re-enters COMPARE to answer.
// ---------------------------------------------------------------------------
module i_cache_dm #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  i_cache_dm_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_MISS_REQ, S_REFILL} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES*LINE_WORDS];
  logic [OFF_W-1:0]  r_beat;
  logic              r_flush_pend;
  logic              r_refilled;   // current COMPARE is the post-refill re-lookup
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_handshake;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_resp_valid;
  logic              w_mem_req_valid;
  logic              w_flush_now;
  logic              w_miss;
  logic              w_count_hit;

  // All lookups work on the latched request address.
  assign w_off       = r_addr[OFF_W-1:0];
  assign w_idx       = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag       = r_addr[ADDR_W-1:OFF_W+IDX_W];
  assign w_hit       = (r_state == S_COMPARE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_beat      = (r_state == S_REFILL) && bus.mem_rdata_valid;
  assign w_last_beat = w_beat && (r_beat == OFF_W'(LINE_WORDS - 1));
  assign w_handshake = (r_state == S_MISS_REQ) && bus.mem_req_ready;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and control decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next          = r_state;
    w_req_ready     = 1'b0;
    w_resp_valid    = 1'b0;
    w_mem_req_valid = 1'b0;
    w_flush_now     = 1'b0;
    w_miss          = 1'b0;
    w_count_hit     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A live or pending flush takes this cycle; the request waits.
        w_req_ready = !bus.flush && !r_flush_pend;
        w_flush_now = bus.flush || r_flush_pend;
        if (bus.req_valid && w_req_ready) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_resp_valid = 1'b1;
          w_count_hit  = !r_refilled;
          w_req_ready  = !bus.flush && !r_flush_pend;
          w_flush_now  = bus.flush;
          w_next       = (bus.req_valid && w_req_ready) ? S_COMPARE : S_IDLE;
        end else begin
          w_miss = 1'b1;
          w_next = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        w_mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_next = S_REFILL;
      end
      S_REFILL: begin
        if (w_last_beat) w_next = S_COMPARE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = bus.req_valid && bus.req_ready;

  // Control/status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_valid      <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_refilled   <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_accept) r_addr <= bus.req_addr;
      if (w_miss)   r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};

      if (w_flush_now)      r_valid        <= '0;
      else if (w_handshake) r_valid[w_idx] <= 1'b0;
      else if (w_last_beat) r_valid[w_idx] <= 1'b1;

      // A flush seen while a miss is in flight is deferred to the next IDLE.
      if (r_state == S_IDLE)             r_flush_pend <= 1'b0;
      else if (bus.flush && !w_flush_now) r_flush_pend <= 1'b1;

      if (w_handshake) r_beat <= '0;
      else if (w_beat) r_beat <= r_beat + OFF_W'(1);

      r_refilled <= w_last_beat;

      if (w_count_hit && (r_hit_cnt != '1))  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != '1))      r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  // Line storage.
  // NOTE: data and tag arrays carry no reset; the valid vector alone decides
  // hits, so their power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (rst && w_beat)      r_data[{w_idx, r_beat}] <= bus.mem_rdata;
    if (rst && w_last_beat) r_tag[w_idx]            <= w_tag;
  end

  assign bus.req_ready     = rst && w_req_ready;
  assign bus.resp_valid    = w_resp_valid;
  assign bus.resp_ins      = w_resp_valid ? r_data[{w_idx, w_off}] : '0;
  assign bus.mem_req_valid = w_mem_req_valid;
  assign bus.mem_req_addr  = r_mem_addr;
  assign bus.hit_cnt       = r_hit_cnt;
  assign bus.miss_cnt      = r_miss_cnt;
endmodule

// File: tb/tb_i_cache_dm.sv
// ---------------------------------------------------------------------------
// tb_i_cache_dm
// Self-checking bench for i_cache_dm (64 lines x 4 words). Directed steps
// followed by random fetches, compared against a line-residency model and a
// memory image held in the bench.
// ---------------------------------------------------------------------------
module tb_i_cache_dm;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  i_cache_dm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  i_cache_dm #(
    .ADDR_W(32), .DATA_W(32), .LINES(64), .LINE_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: which line base address each index holds, plus counters.
  bit          mdl_valid [64];
  logic [31:0] mdl_line  [64];
  int unsigned mdl_hits   = 0;
  int unsigned mdl_misses = 0;

  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] stream_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd64);
  endfunction

  task automatic invalidate_all();
    for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  bus.hit_cnt,  mdl_hits);
    check({tag, "_miss_cnt"}, bus.miss_cnt, mdl_misses);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE, acting as memory on a miss.
  // flush_mode: 0 none, 1 flush during refill, 2 flush in the response cycle.
  task automatic do_fetch(input logic [31:0] a, input int rdy_dly,
                          input int flush_mode, input bit gaps);
    int          ix;
    logic [31:0] ln;
    bit          hit;
    bit          acc;
    int          cyc;
    int          b;
    ix  = idx_of(a);
    ln  = a - (a % 32'd4);
    hit = mdl_valid[ix] && (mdl_line[ix] == ln);

    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 20) begin
      #2;
      acc = bus.req_ready;
      next_cycle();
      cyc++;
    end
    bus.req_valid = 1'b0;
    check("accept", {31'd0, acc}, 32'd1);
    if (!acc) return;

    if (hit) begin
      bus.flush = (flush_mode == 2);
      #2;
      check("hit_resp_valid", bus.resp_valid, 32'd1);
      check("hit_resp_ins", bus.resp_ins, mem_word(a));
      if (flush_mode == 2) check("hit_flush_blocks_ready", bus.req_ready, 32'd0);
      mdl_hits++;
      next_cycle();
      bus.flush = 1'b0;
      if (flush_mode == 2) invalidate_all();
    end else begin
      #2;
      check("miss_no_resp", bus.resp_valid, 32'd0);
      check("miss_not_ready", bus.req_ready, 32'd0);
      mdl_misses++;
      next_cycle();
      // Memory holds off the request; junk beats must be ignored meanwhile.
      for (int k = 0; k <= rdy_dly; k++) begin
        bus.mem_req_ready   = (k == rdy_dly);
        bus.mem_rdata_valid = (k != rdy_dly);
        bus.mem_rdata       = 32'hDEAD_0000 + k;
        #2;
        check("mem_req_valid", bus.mem_req_valid, 32'd1);
        check("mem_req_addr", bus.mem_req_addr, ln);
        next_cycle();
      end
      bus.mem_req_ready = 1'b0;
      b = 0;
      while (b < 4) begin
        bus.flush = (flush_mode == 1) && (b == 0);
        if (gaps && $urandom_range(0, 2) == 0) begin
          bus.mem_rdata_valid = 1'b0;
          bus.mem_rdata       = $urandom;
        end else begin
          bus.mem_rdata_valid = 1'b1;
          bus.mem_rdata       = mem_word(ln + b);
          b++;
        end
        #2;
        check("refill_no_resp", bus.resp_valid, 32'd0);
        check("refill_no_mem_req", bus.mem_req_valid, 32'd0);
        next_cycle();
      end
      bus.mem_rdata_valid = 1'b0;
      bus.flush           = (flush_mode == 2);
      #2;
      check("refill_resp_valid", bus.resp_valid, 32'd1);
      check("refill_resp_ins", bus.resp_ins, mem_word(a));
      if (flush_mode != 0) check("refill_flush_blocks_ready", bus.req_ready, 32'd0);
      next_cycle();
      bus.flush     = 1'b0;
      mdl_valid[ix] = 1'b1;
      mdl_line[ix]  = ln;
      if (flush_mode == 1) begin
        #2;
        check("pending_flush_ready_low", bus.req_ready, 32'd0);
        next_cycle();
      end
      if (flush_mode != 0) invalidate_all();
    end
    check_counters("fetch");
  endtask

  // Back-to-back requests that the model expects to hit.
  task automatic stream_hits();
    int n;
    n = stream_q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = stream_q[i];
      end else begin
        bus.req_valid = 1'b0;
      end
      #2;
      if (i > 0) begin
        check("stream_resp_valid", bus.resp_valid, 32'd1);
        check("stream_resp_ins", bus.resp_ins, mem_word(stream_q[i-1]));
        mdl_hits++;
      end
      if (i < n) check("stream_ready", bus.req_ready, 32'd1);
      next_cycle();
    end
    check_counters("stream");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst                 = 1'b0;
    bus.req_valid       = 1'b0;
    bus.req_addr        = '0;
    bus.flush           = 1'b0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    for (int i = 0; i < 4; i++) begin
      mem_img[32'h10 + i]  = 32'hA0 + i;
      mem_img[32'h110 + i] = 32'hB0 + i;
    end

    // Reset held for two edges.
    next_cycle();
    #2;
    check("reset_ready_low", bus.req_ready, 32'd0);
    next_cycle();
    check("reset_resp_valid", bus.resp_valid, 32'd0);
    check("reset_resp_ins", bus.resp_ins, 32'd0);
    check("reset_mem_req_valid", bus.mem_req_valid, 32'd0);
    check("reset_mem_req_addr", bus.mem_req_addr, 32'd0);
    check_counters("reset");
    rst = 1'b1;
    #2;
    check("post_reset_ready", bus.req_ready, 32'd1);
    next_cycle();

    // Cold miss, line hits back to back, conflict eviction.
    do_fetch(32'h10, 0, 0, 1'b0);
    stream_q = '{32'h11, 32'h12, 32'h13};
    stream_hits();
    do_fetch(32'h110, 0, 0, 1'b0);
    do_fetch(32'h10, 0, 0, 1'b0);
    check("conflict_miss_cnt", bus.miss_cnt, 32'd3);

    // Memory backpressure for 5 cycles.
    do_fetch(32'h14, 5, 0, 1'b1);

    // Flush in IDLE together with a request: flush wins.
    do_fetch(32'h10, 0, 0, 1'b0);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    #2;
    check("flush_beats_request", bus.req_ready, 32'd0);
    next_cycle();
    bus.flush = 1'b0;
    invalidate_all();
    do_fetch(32'h10, 0, 0, 1'b0);

    // Flush during refill, then flush during a hit response.
    do_fetch(32'h18, 1, 1, 1'b0);
    do_fetch(32'h10, 0, 0, 1'b0);
    do_fetch(32'h11, 0, 2, 1'b0);
    do_fetch(32'h11, 0, 0, 1'b0);

    // Reset after two of four beats.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h24;
    next_cycle();
    bus.req_valid = 1'b0;
    next_cycle();
    bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = mem_word(32'h24 + k);
      next_cycle();
    end
    rst           = 1'b0;
    bus.mem_rdata = 32'hBAD0_0000;
    next_cycle();
    #2;
    check("midreset_ready_low", bus.req_ready, 32'd0);
    next_cycle();
    rst = 1'b1;
    invalidate_all();
    mdl_hits   = 0;
    mdl_misses = 0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_rdata = 32'hBAD1_0000 + k;
      #2;
      check("midreset_idle_ready", bus.req_ready, 32'd1);
      check("midreset_no_resp", bus.resp_valid, 32'd0);
      check("midreset_no_mem_req", bus.mem_req_valid, 32'd0);
      next_cycle();
    end
    bus.mem_rdata_valid = 1'b0;
    check_counters("midreset");
    do_fetch(32'h24, 0, 0, 1'b0);
    do_fetch(32'h27, 0, 0, 1'b0);

    // Random fetches over a few tags and indices so hits and conflicts mix.
    for (int n = 0; n < 200; n++) begin
      a = $urandom_range(0, 3) * 256 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
      do_fetch(a, int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0,
               1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i_cache_dm.md
Name: i_cache_dm

Overview:
- Parametrised direct-mapped instruction cache; replaces the flat word-array instruction store in front of the fetch stage.
- CPU side takes word addresses (pc >> 2) through a valid/ready request and returns an instruction with a registered response.
- Misses refill a whole line from the backing instruction memory through a request handshake followed by a burst of word beats.
- Provides a flush (invalidate-all) input and saturating hit/miss counters.

Parameters:
ADDR_W, 32, CPU word-address width.
DATA_W, 32, instruction/word width.
LINES, 64, number of cache lines (power of two, >=2).
LINE_WORDS, 4, words per line (power of two, >=2).
Derived: OFF_W=log2(LINE_WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
req_valid  in  1  fetch request valid
req_ready  out  1  cache can accept request this cycle
req_addr  in  ADDR_W  word address (pc >> 2)
resp_valid  out  1  ins valid this cycle (one-cycle pulse per request)
resp_ins  out  DATA_W  instruction
flush  in  1  invalidate all lines
mem_req_valid  out  1  line refill request
mem_req_ready  in  1  memory accepts refill request
mem_req_addr  out  ADDR_W  line base word address (offset bits zero)
mem_rdata_valid  in  1  refill beat valid
mem_rdata  in  DATA_W  refill beat, words in ascending offset order
hit_cnt  out  32  saturating hit count
miss_cnt  out  32  saturating miss count

Behaviour:
- Address split: offset = addr[OFF_W-1:0], index = addr[OFF_W+IDX_W-1:OFF_W], tag = upper TAG_W bits.
- Storage: data array LINES*LINE_WORDS words, tag array, valid bit vector. Power-up contents of data/tag are don't-care; valid bits alone define hits.
- Reset (rst==0 at clk edge): all valid bits 0, state IDLE, req_ready 0 during reset then 1, resp_valid 0, resp_ins 0, mem_req_valid 0, mem_req_addr 0, counters 0, pending flush cleared. Reset mid-refill aborts the refill; later mem_rdata_valid beats are ignored while not in REFILL.
- FSM states: IDLE, COMPARE, MISS_REQ, REFILL.
- IDLE: req_ready=1 unless flush pending. On req_valid&&req_ready, latch addr -> COMPARE.
- COMPARE: hit = valid[index] && tag match.
  - Hit: resp_valid=1, resp_ins = word, hit_cnt++. req_ready=1 in this cycle, giving back-to-back hits one response per cycle. Next state is COMPARE if a new request is accepted, else IDLE. Hit latency is 1 cycle from acceptance.
  - Miss: resp_valid=0, req_ready=0, miss_cnt++ once per request, mem_req_addr = {tag,index,0} -> MISS_REQ.
- MISS_REQ: mem_req_valid=1, held with stable address until mem_req_ready. On handshake, valid[index] is cleared and the state goes to REFILL.
- REFILL: each mem_rdata_valid beat writes word at beat counter 0..LINE_WORDS-1. On the last beat, write tag and set valid[index] -> COMPARE, which re-looks-up the latched address and hits. That re-lookup is not counted as a hit.
- Miss penalty = 1 (COMPARE) + handshake cycles + LINE_WORDS beat cycles + 1 (COMPARE hit).
- Flush:
  - Sampled in IDLE or in a COMPARE-hit cycle: all valid bits cleared at that edge, and no request is accepted that cycle.
  - In MISS_REQ/REFILL: latched as pending. The in-progress refill and its response complete normally. Valid bits are cleared on the first cycle back in IDLE, and req_ready=0 until done.
- Simultaneous flush and req_valid: flush wins; the request waits.
- Counters saturate at 0xFFFF_FFFF; no wrap.
- Requester must hold req_valid/req_addr until accepted. resp_valid has no backpressure.

Test Plan:
- Reset then cold miss: rst low 2 cycles; req 0x10 -> miss_cnt=1, mem_req_addr=0x10. Beats 0xA0..0xA3 -> resp_valid with resp_ins=0xA0 at COMPARE after last beat, hit_cnt=0.
- Line hits back-to-back: after fill, req 0x11,0x12,0x13 on consecutive cycles -> responses 0xA1,0xA2,0xA3 on consecutive cycles, each 1 cycle after acceptance, hit_cnt=3.
- Conflict eviction: req 0x110 (same index 4, new tag) -> miss, mem_req_addr=0x110. Refill 0xB0..0xB3; then req 0x10 -> miss again, miss_cnt=3.
- Memory backpressure: mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr stable throughout, no beats consumed early, correct data returned.
- Flush: after fill, assert flush in IDLE -> next req 0x10 misses. Flush asserted during REFILL -> current response still delivered with refilled data, then req 0x10 misses.
- Reset mid-refill: drop rst after 2 of 4 beats -> valid[index]=0, state IDLE, remaining beats ignored; later req to same line issues fresh mem_req.
